// File: rtl/sgbm_pkg.sv
// Shared definitions for the winner-take-all disparity selector:
// FSM state encoding, the invalid-disparity marker and default parameters.
package sgbm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CHECK = 2'd2,
        ST_OUT   = 2'd3
    } wta_state_t;

    // All-ones marker; the top slices it down to its own DISP_W.
    localparam logic [31:0] INVALID_DISP = 32'hFFFF_FFFF;

    localparam int DEF_DISP_NUM = 96;
    localparam int DEF_COST_W   = 9;
    localparam int DEF_LANES    = 8;
    localparam int DEF_UNIQ_PCT = 10;
    localparam int DEF_DISP_W   = 8;
    localparam int DEF_ROW_W    = 10;
    localparam int DEF_COL_W    = 10;

endpackage

// File: rtl/disp_lane_min2.sv
// Combinational min / argmin / second-min over one beat of LANES costs.
// Lowest lane index wins ties; an equal cost then becomes the second minimum.
module disp_lane_min2 #(
    parameter int LANES  = 8,
    parameter int COST_W = 9,
    parameter int IDX_W  = 3
) (
    input  logic [LANES*COST_W-1:0] costs,
    output logic [COST_W-1:0]       lane_min,
    output logic [IDX_W-1:0]        lane_idx,
    output logic [COST_W-1:0]       lane_sec
);

    // Linear scan across the lanes; strict '<' keeps the lower index on ties.
    always_comb begin
        lane_min = costs[COST_W-1:0];
        lane_idx = '0;
        lane_sec = '1;
        for (int i = 1; i < LANES; i++) begin
            if (costs[i*COST_W +: COST_W] < lane_min) begin
                lane_sec = lane_min;
                lane_min = costs[i*COST_W +: COST_W];
                lane_idx = IDX_W'(i);
            end else if (costs[i*COST_W +: COST_W] < lane_sec) begin
                lane_sec = costs[i*COST_W +: COST_W];
            end
        end
    end

endmodule

// File: rtl/disparity_wta_param.sv
// Winner-take-all disparity selection with uniqueness check.
// A pixel's cost vector is captured in IDLE, scanned LANES candidates per
// cycle, then the ratio test decides between the winning index and INVALID.
//
//   state | meaning
//   IDLE  | waiting for a pixel, in_ready high
//   SCAN  | merging one beat of LANES costs per cycle into (min, pos, sec)
//   CHECK | uniqueness ratio evaluated, result registered
//   OUT   | result held with valid high until out_ready
module disparity_wta_param
    import sgbm_pkg::*;
#(
    parameter int DISP_NUM = DEF_DISP_NUM,
    parameter int COST_W   = DEF_COST_W,
    parameter int LANES    = DEF_LANES,
    parameter int UNIQ_PCT = DEF_UNIQ_PCT,
    parameter int DISP_W   = DEF_DISP_W,
    parameter int ROW_W    = DEF_ROW_W,
    parameter int COL_W    = DEF_COL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic                       in_ready,
    input  logic [DISP_NUM*COST_W-1:0] cost_aggr,
    input  logic [ROW_W-1:0]           row_in,
    input  logic [COL_W-1:0]           col_in,
    input  logic                       check_en,
    output logic [DISP_W-1:0]          disparity,
    output logic [COST_W-1:0]          min_cost,
    output logic [COST_W-1:0]          sec_min_cost,
    output logic                       unique_out,
    output logic [ROW_W-1:0]           row_out,
    output logic [COL_W-1:0]           col_out,
    output logic                       valid,
    input  logic                       out_ready
);

    localparam int NB     = DISP_NUM / LANES;
    localparam int BCW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int LIW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BEAT_W = LANES * COST_W;
    localparam int PROD_W = COST_W + 7;
    localparam logic [DISP_W-1:0] INV       = INVALID_DISP[DISP_W-1:0];
    localparam logic [BCW-1:0]    LAST_BEAT = BCW'(NB - 1);

    wta_state_t state, state_nx;

    logic [DISP_NUM*COST_W-1:0] cost_r;
    logic [ROW_W-1:0]           row_r;
    logic [COL_W-1:0]           col_r;
    logic                       chk_r;
    logic [BCW-1:0]             beat;
    logic [COST_W-1:0]          run_min, run_sec;
    logic [DISP_W-1:0]          run_pos;

    logic [BEAT_W-1:0]  beat_costs;
    logic [COST_W-1:0]  lane_min, lane_sec;
    logic [LIW-1:0]     lane_idx;
    logic [DISP_W-1:0]  gidx;
    logic [COST_W-1:0]  merge_min, merge_sec;
    logic [DISP_W-1:0]  merge_pos;
    logic [PROD_W-1:0]  lhs, rhs;
    logic               uniq;

    assign beat_costs = cost_r[int'(beat)*BEAT_W +: BEAT_W];

    disp_lane_min2 #(
        .LANES  (LANES),
        .COST_W (COST_W),
        .IDX_W  (LIW)
    ) u_lane_min2 (
        .costs    (beat_costs),
        .lane_min (lane_min),
        .lane_idx (lane_idx),
        .lane_sec (lane_sec)
    );

    assign gidx = DISP_W'(int'(beat) * LANES + int'(lane_idx));

    // Fold the beat into the running result. Beat indices are always higher
    // than run_pos, so an equal beat minimum only competes for second place.
    always_comb begin
        merge_min = run_min;
        merge_pos = run_pos;
        merge_sec = run_sec;
        if (lane_min < run_min) begin
            merge_min = lane_min;
            merge_pos = gidx;
            merge_sec = (lane_sec < run_min) ? lane_sec : run_min;
        end else if (lane_min < run_sec) begin
            merge_sec = lane_min;
        end
    end

    // Ratio test widened so neither product can overflow.
    assign lhs  = PROD_W'(run_min) * PROD_W'(100);
    assign rhs  = PROD_W'(run_sec) * PROD_W'(100 - UNIQ_PCT);
    assign uniq = (lhs <= rhs);

    assign in_ready = (state == ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (en)                 state_nx = ST_SCAN;
            ST_SCAN:  if (beat == LAST_BEAT)  state_nx = ST_CHECK;
            ST_CHECK:                         state_nx = ST_OUT;
            ST_OUT:   if (out_ready)          state_nx = ST_IDLE;
            default:                          state_nx = ST_IDLE;
        endcase
    end

    // Capture, scan accumulation and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cost_r       <= '0;
            row_r        <= '0;
            col_r        <= '0;
            chk_r        <= 1'b0;
            beat         <= '0;
            run_min      <= '0;
            run_sec      <= '0;
            run_pos      <= '0;
            disparity    <= '0;
            min_cost     <= '0;
            sec_min_cost <= '0;
            unique_out   <= 1'b0;
            row_out      <= '0;
            col_out      <= '0;
            valid        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        cost_r  <= cost_aggr;
                        row_r   <= row_in;
                        col_r   <= col_in;
                        chk_r   <= check_en;
                        beat    <= '0;
                        run_min <= '1;
                        run_sec <= '1;
                        run_pos <= '0;
                    end
                end
                ST_SCAN: begin
                    run_min <= merge_min;
                    run_sec <= merge_sec;
                    run_pos <= merge_pos;
                    beat    <= beat + 1'b1;
                end
                ST_CHECK: begin
                    disparity    <= (chk_r && !uniq) ? INV : run_pos;
                    min_cost     <= run_min;
                    sec_min_cost <= run_sec;
                    unique_out   <= uniq;
                    row_out      <= row_r;
                    col_out      <= col_r;
                    valid        <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/disparity_wta_param.md
DISPARITY_WTA_PARAM -- requirements
Module: disparity_wta_param

Interface
REQ-001 SHALL have parameter DISP_NUM, default 96: number of candidate disparities (>=2).
REQ-002 SHALL have parameter COST_W, default 9: width of one aggregated cost.
REQ-003 SHALL have parameter LANES, default 8: candidates compared per cycle; DISP_NUM % LANES == 0.
REQ-004 SHALL have parameter UNIQ_PCT, default 10: uniqueness ratio in percent (0..99).
REQ-005 SHALL have parameter DISP_W, default 8: output disparity width; DISP_NUM <= 2^DISP_W-1.
REQ-006 SHALL have parameters ROW_W and COL_W, both default 10: coordinate widths.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port en, input, 1: input valid.
REQ-010 SHALL have port in_ready, output, 1: block can accept a pixel.
REQ-011 SHALL have port cost_aggr, input, DISP_NUM*COST_W: costs; d occupies bits [d*COST_W +: COST_W].
REQ-012 SHALL have ports row_in (input, ROW_W) and col_in (input, COL_W): pixel coordinate.
REQ-013 SHALL have port check_en, input, 1: enables the uniqueness check, sampled at accept.
REQ-014 SHALL have port disparity, output, DISP_W: winning index, or INVALID (all ones).
REQ-015 SHALL have ports min_cost (output, COST_W) and sec_min_cost (output, COST_W).
REQ-016 SHALL have port unique_out, output, 1: uniqueness test passed.
REQ-017 SHALL have ports row_out (output, ROW_W) and col_out (output, COL_W).
REQ-018 SHALL have port valid, output, 1: result valid.
REQ-019 SHALL have port out_ready, input, 1: downstream accepts the result.

Function
REQ-020 SHALL use FSM states IDLE, SCAN, CHECK, OUT; in_ready = (state==IDLE).
REQ-021 SHALL, in IDLE on en&&in_ready, register cost_aggr, row_in, col_in and check_en, clear beat counter, min := all ones, sec := all ones, and go to SCAN.
REQ-022 SHALL, in SCAN, process beat k (disparities k*LANES..k*LANES+LANES-1) each cycle for NB = DISP_NUM/LANES cycles, then go to CHECK.
REQ-023 SHALL merge each beat into running (min, pos, sec) so that min/pos track the strict minimum with the lowest index winning ties, and sec is the smallest cost among all indices other than pos (an equal-cost tie becomes sec).
REQ-024 SHALL, in CHECK, compute uniq = (min*100 <= sec*(100-UNIQ_PCT)) at width COST_W+7, with no truncation.
REQ-025 SHALL, at the CHECK edge, register disparity = (check_en && !uniq) ? INVALID : pos, together with min_cost, sec_min_cost, unique_out = uniq, row_out and col_out; set valid=1 and go to OUT.
REQ-026 SHALL raise valid exactly NB+1 rising edges after the accept edge (13 with defaults).
REQ-027 SHALL hold valid and all result outputs stable in OUT until out_ready=1; on that edge valid := 0 and state := IDLE.
REQ-028 SHALL ignore en outside IDLE; no input is buffered and none is dropped silently, because in_ready=0.
REQ-029 SHALL keep result outputs at their last values while valid=0.

Reset
REQ-030 SHALL, on rst=1 at any time, including mid-SCAN or in OUT, force state IDLE, valid 0, disparity, min_cost, sec_min_cost, unique_out, row_out, col_out to 0, and internal accumulators to 0, discarding the pixel in flight.
REQ-031 SHALL assert in_ready=1 on the first cycle after rst deasserts.

Structure
REQ-032 SHALL place the state encoding, the INVALID_DISP constant and the default parameter values in shared package sgbm_pkg.
REQ-033 SHALL use one combinational sub-module disp_lane_min2 that returns local min, index and second-min over LANES candidates, instantiated once.

Verification (DISP_NUM=96, COST_W=9, LANES=8, UNIQ_PCT=10)
REQ-034 SHALL cover: all costs 200, d37=50, d80=120, check_en=1 -> disparity 37, min 50, sec 120, unique_out 1, valid 13 edges after accept.
REQ-035 SHALL cover: d5=30, d70=30, others 511 -> check_en=1 gives disparity 0xFF, sec 30, unique_out 0; check_en=0 gives disparity 5.
REQ-036 SHALL cover the ratio boundary: d10=90, d11=100, others 511 -> disparity 10 (9000<=9000); with d10=91 -> 0xFF.
REQ-037 SHALL cover backpressure: out_ready low for 5 cycles -> outputs stable, in_ready 0, en pulses ignored; the next pixel is accepted in the cycle after release.
REQ-038 SHALL cover reset at SCAN beat 6: all outputs 0 and in_ready 1 after release; the next pixel gives the correct result.
REQ-039 SHALL cover lane edges: min at d95, sec at d0 -> disparity 95; and repeat the REQ-034 scenario with LANES=1 (valid after 97 edges) and LANES=96 (valid after 2 edges).
